// File: rtl/qpp_pkg.sv
// Shared QPP constants, types and the modular-add helper used by the (de)interleaver blocks.
package qpp_pkg;

  localparam int unsigned KMAX    = 6144;
  localparam int unsigned AW      = 13;
  localparam int unsigned K_SMALL = 1056;
  localparam int unsigned F1_S    = 17;
  localparam int unsigned F2_S    = 66;
  localparam int unsigned F1_L    = 263;
  localparam int unsigned F2_L    = 480;
  localparam int unsigned NBYTES  = KMAX / 8;
  localparam int unsigned BCNT_W  = AW - 3;

  typedef logic [AW-1:0]     addr_t;
  typedef logic [BCNT_W-1:0] bcnt_t;

  typedef enum logic [1:0] {StIdle, StFill, StDrain} deint_state_e;

  // Both operands are already reduced mod k, so a single conditional subtract is enough.
  function automatic addr_t qpp_step(input addr_t a, input addr_t b, input addr_t k);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, k}) begin
      sum = sum - {1'b0, k};
    end
    return sum[AW-1:0];
  endfunction

  function automatic addr_t k_of(input logic big);
    return big ? addr_t'(KMAX) : addr_t'(K_SMALL);
  endfunction

  function automatic addr_t f1_of(input logic big);
    return big ? addr_t'(F1_L) : addr_t'(F1_S);
  endfunction

  function automatic addr_t f2_of(input logic big);
    return big ? addr_t'(F2_L) : addr_t'(F2_S);
  endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Recursive QPP address generator: pi(i) = f1*i + f2*i^2 mod K using adds only.
module qpp_addr_gen
  import qpp_pkg::*;
(
  input  logic  clk_i,
  input  logic  clear_i,
  input  logic  load_i,
  input  logic  advance_i,
  input  addr_t k_i,
  input  addr_t f1_i,
  input  addr_t f2_i,
  output addr_t pi_o
);

  addr_t pi_q, pi_d;
  addr_t g_q, g_d;
  addr_t two_f2;
  addr_t g0;

  assign two_f2 = qpp_step(f2_i, f2_i, k_i);
  assign g0     = qpp_step(f1_i, f2_i, k_i);

  // Load leaves pi at pi(1) and g at the step pi(1)->pi(2); pi(0)=0 is handled by the caller.
  always_comb begin
    pi_d = pi_q;
    g_d  = g_q;
    if (load_i) begin
      pi_d = g0;
      g_d  = qpp_step(g0, two_f2, k_i);
    end else if (advance_i) begin
      pi_d = qpp_step(pi_q, g_q, k_i);
      g_d  = qpp_step(g_q, two_f2, k_i);
    end
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      pi_q <= '0;
      g_q  <= '0;
    end else begin
      pi_q <= pi_d;
      g_q  <= g_d;
    end
  end

  assign pi_o = pi_q;

endmodule

// File: rtl/qpp_deint_rx.sv
// QPP de-interleaving receiver: serial bits in interleaved order, bytes out in natural order.
// Optional QPP_DEINT_BYPASS_EN adds deint_bypass to write in natural (index) order instead.
module qpp_deint_rx
  import qpp_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       k_size_6144,
`ifdef QPP_DEINT_BYPASS_EN
  input  logic       deint_bypass,
`endif
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       block_done
);

  deint_state_e state_q, state_d;
  logic         k_big_q, k_big_d;
  logic         bypass_q, bypass_d;
  addr_t        idx_q, idx_d;
  bcnt_t        bcnt_q, bcnt_d;
  logic [7:0]   byte_q, byte_d;
  logic         byte_valid_q, byte_valid_d;
  logic         block_done_q, block_done_d;

  logic [7:0]   mem_q [NBYTES];

  logic         in_idle;
  logic         k_big_cur;
  logic         bypass_cur;
  addr_t        k_cur, f1_cur, f2_cur;
  addr_t        pi;
  addr_t        wr_addr;
  logic         bit_acc;
  logic         gen_load, gen_adv;
  logic         last_bit;
  bcnt_t        last_byte;
  logic [7:0]   fwd_byte;

  assign in_idle   = (state_q == StIdle);
  // Block parameters come straight from the inputs in IDLE and from the latch afterwards.
  assign k_big_cur = in_idle ? k_size_6144 : k_big_q;
`ifdef QPP_DEINT_BYPASS_EN
  assign bypass_cur = in_idle ? deint_bypass : bypass_q;
`else
  assign bypass_cur = 1'b0;
`endif
  assign k_cur  = k_of(k_big_cur);
  assign f1_cur = f1_of(k_big_cur);
  assign f2_cur = f2_of(k_big_cur);

  assign bit_ready = (state_q != StDrain);
  assign bit_acc   = bit_valid & bit_ready;
  assign gen_load  = in_idle & bit_valid;
  assign gen_adv   = (state_q == StFill) & bit_valid;

  assign wr_addr   = in_idle ? '0 : (bypass_q ? idx_q : pi);
  assign last_bit  = (idx_q == k_cur - addr_t'(1));
  assign last_byte = bcnt_t'(k_cur >> 3) - bcnt_t'(1);

  qpp_addr_gen u_addr_gen (
    .clk_i     (clk),
    .clear_i   (clear),
    .load_i    (gen_load),
    .advance_i (gen_adv),
    .k_i       (k_cur),
    .f1_i      (f1_cur),
    .f2_i      (f2_cur),
    .pi_o      (pi)
  );

  // Byte 0 is loaded on the same edge as the final write, so forward that bit if it lands there.
  always_comb begin
    fwd_byte = mem_q[0];
    if (wr_addr[AW-1:3] == '0) begin
      fwd_byte[~wr_addr[2:0]] = bit_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_big_d      = k_big_q;
    bypass_d     = bypass_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q;
    block_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bit_valid) begin
          k_big_d  = k_size_6144;
          bypass_d = bypass_cur;
          idx_d    = addr_t'(1);
          state_d  = StFill;
        end
      end
      StFill: begin
        if (bit_valid) begin
          if (last_bit) begin
            idx_d        = '0;
            bcnt_d       = '0;
            byte_d       = fwd_byte;
            byte_valid_d = 1'b1;
            state_d      = StDrain;
          end else begin
            idx_d = idx_q + addr_t'(1);
          end
        end
      end
      StDrain: begin
        if (byte_valid_q && byte_ready) begin
          if (bcnt_q == last_byte) begin
            byte_d       = '0;
            byte_valid_d = 1'b0;
            block_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            bcnt_d = bcnt_q + bcnt_t'(1);
            byte_d = mem_q[bcnt_q + bcnt_t'(1)];
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= StIdle;
      k_big_q      <= 1'b0;
      bypass_q     <= 1'b0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_big_q      <= k_big_d;
      bypass_q     <= bypass_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      block_done_q <= block_done_d;
    end
  end

  // Block buffer, stored MSB-first per byte; never cleared since pi covers every position.
  always_ff @(posedge clk) begin
    if (bit_acc) begin
      mem_q[wr_addr[AW-1:3]][~wr_addr[2:0]] <= bit_in;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign block_done = block_done_q;

endmodule

// File: tb/tb_qpp_deint_rx.sv
// Directed bench for qpp_deint_rx: table of whole-block vectors plus reset, address and
// back-to-back sequences.
module tb_qpp_deint_rx;
  import qpp_pkg::*;

  logic       clk = 1'b0;
  logic       clear;
  logic       k_size_6144;
  logic       deint_bypass;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       block_done;

  int total  = 0;
  int passed = 0;
  int done_cnt = 0;

  bit         cbits [KMAX];
  logic [7:0] expb  [KMAX/8];

  typedef struct {
    bit         big;
    logic [7:0] seed;
    bit         gaps;
    bit         stall;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  always @(negedge clk) if (block_done === 1'b1) done_cnt++;

  qpp_deint_rx dut (
    .clk         (clk),
    .clear       (clear),
    .k_size_6144 (k_size_6144),
`ifdef QPP_DEINT_BYPASS_EN
    .deint_bypass(deint_bypass),
`endif
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .block_done  (block_done)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Independent closed-form QPP model.
  function automatic int pi_f(input int i, input bit big);
    longint k, f1, f2, li;
    k  = big ? 6144 : 1056;
    f1 = big ? 263 : 17;
    f2 = big ? 480 : 66;
    li = i;
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  function automatic logic [7:0] sbyte(input logic [7:0] seed, input int n);
    return 8'(seed + 8'(n * 37)) ^ 8'(n >> 5);
  endfunction

  task automatic build(input logic [7:0] seed, input bit big, input bit nat);
    int k;
    int p;
    k = big ? 6144 : 1056;
    for (int n = 0; n < k / 8; n++) expb[n] = sbyte(seed, n);
    for (int i = 0; i < k; i++) begin
      p = nat ? i : pi_f(i, big);
      cbits[i] = expb[p / 8][7 - (p % 8)];
    end
  endtask

  task automatic feed(input bit big, input int nbits, input bit gaps, input int toggle_at,
                      output int early, output int sent);
    int  guard;
    bit  acc;
    bit  tog_done;
    early    = 0;
    sent     = 0;
    guard    = 0;
    tog_done = 0;
    k_size_6144 = big;
    while (sent < nbits && guard < 40000) begin
      guard++;
      if (sent == toggle_at && !tog_done) begin
        k_size_6144 = ~k_size_6144;
        tog_done    = 1;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        bit_valid = 1'b0;
      end else begin
        bit_valid = 1'b1;
        bit_in    = cbits[sent];
      end
      if (byte_valid !== 1'b0) early++;
      acc = bit_valid && (bit_ready === 1'b1);
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    bit_valid = 1'b0;
  endtask

  task automatic drain(input bit big, input bit stall, output int mism, output int unstable,
                       output int rdyv, output int nbytes, output logic [7:0] first);
    int         nb;
    int         cyc;
    bit         held_v;
    logic [7:0] held;
    bit         rdy;
    bit [3:0]   pat;
    pat      = 4'b1001;
    nb       = big ? 768 : 132;
    nbytes   = 0;
    cyc      = 0;
    held_v   = 0;
    held     = '0;
    mism     = 0;
    unstable = 0;
    rdyv     = 0;
    first    = '0;
    while (nbytes < nb && cyc < 4 * nb + 50) begin
      rdy = stall ? pat[cyc % 4] : 1'b1;
      byte_ready = rdy;
      if (bit_ready !== 1'b0) rdyv++;
      if (byte_valid === 1'b1) begin
        if (held_v && byte_out !== held) unstable++;
        if (rdy) begin
          if (nbytes == 0) first = byte_out;
          if (byte_out !== expb[nbytes]) mism++;
          nbytes++;
          held_v = 0;
        end else begin
          held   = byte_out;
          held_v = 1;
        end
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    byte_ready = 1'b0;
  endtask

  // mode: 0 = interleaved source, 1 = natural-order source, 2 = cbits/expb prebuilt.
  task automatic run_blk(input string name, input bit big, input logic [7:0] seed,
                         input bit gaps, input bit stall, input int toggle_at,
                         input logic [7:0] exp_first, input int mode);
    int         k;
    int         early, sent, mism, unstable, rdyv, nbytes;
    logic [7:0] first;
    k = big ? 6144 : 1056;
    if (mode != 2) build(seed, big, mode == 1);
    feed(big, k, gaps, toggle_at, early, sent);
    chk({name, " no early byte_valid"}, early, 0);
    chk({name, " bits accepted"}, sent, k);
    chk({name, " byte_valid after last bit"}, byte_valid, 1);
    drain(big, stall, mism, unstable, rdyv, nbytes, first);
    if (mode != 2) chk({name, " first byte"}, first, exp_first);
    chk({name, " byte mismatches"}, mism, 0);
    chk({name, " byte count"}, nbytes, k / 8);
    chk({name, " byte_out stable in stall"}, unstable, 0);
    chk({name, " bit_ready low in drain"}, rdyv, 0);
    chk({name, " block_done pulse"}, block_done, 1);
    chk({name, " byte_valid low at done"}, byte_valid, 0);
    @(posedge clk);
    #1;
    chk({name, " block_done one cycle"}, block_done, 0);
  endtask

  initial begin
    int d0;
    int early, sent;

    vecs[0] = '{big: 1'b0, seed: 8'h5A, gaps: 1'b0, stall: 1'b0, exp_first: 8'h5A};
    vecs[1] = '{big: 1'b1, seed: 8'hBF, gaps: 1'b0, stall: 1'b0, exp_first: 8'hBF};
    vecs[2] = '{big: 1'b0, seed: 8'h3C, gaps: 1'b1, stall: 1'b1, exp_first: 8'h3C};

    clear        = 1'b1;
    k_size_6144  = 1'b0;
    deint_bypass = 1'b0;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    byte_ready   = 1'b0;
    #2;
    chk("reset bit_ready", bit_ready, 1);
    chk("reset byte_valid", byte_valid, 0);
    chk("reset byte_out", byte_out, 0);
    chk("reset block_done", block_done, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;

    for (int v = 0; v < 3; v++) begin
      d0 = done_cnt;
      run_blk($sformatf("vec%0d", v), vecs[v].big, vecs[v].seed, vecs[v].gaps,
              vecs[v].stall, -1, vecs[v].exp_first, 0);
      chk($sformatf("vec%0d done count", v), done_cnt - d0, 1);
    end

    // Single ones at c_1 and c_2: pi(1)=743 -> byte 92 = 0x01, pi(2)=2446 -> byte 305 = 0x02.
    for (int i = 0; i < KMAX; i++) cbits[i] = 1'b0;
    for (int n = 0; n < KMAX / 8; n++) expb[n] = 8'h00;
    cbits[1]   = 1'b1;
    cbits[2]   = 1'b1;
    expb[92]   = 8'h01;
    expb[305]  = 8'h02;
    run_blk("addr6144", 1'b1, 8'h00, 1'b0, 1'b0, -1, 8'h00, 2);

    // Abandon a block part way through, then decode a clean one.
    d0 = done_cnt;
    build(8'h5A, 1'b0, 1'b0);
    feed(1'b0, 500, 1'b0, -1, early, sent);
    chk("midrst bits sent", sent, 500);
    clear = 1'b1;
    #1;
    chk("midrst bit_ready", bit_ready, 1);
    chk("midrst byte_valid", byte_valid, 0);
    chk("midrst byte_out", byte_out, 0);
    chk("midrst block_done", block_done, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    run_blk("postrst", 1'b0, 8'h42, 1'b0, 1'b0, -1, 8'h42, 0);
    chk("midrst done count", done_cnt - d0, 1);

    // Back-to-back: k_size_6144 flips mid-block and must only affect the next block.
    d0 = done_cnt;
    run_blk("b2b big", 1'b1, 8'h11, 1'b0, 1'b0, 3000, 8'h11, 0);
    run_blk("b2b small", 1'b0, 8'h77, 1'b0, 1'b0, -1, 8'h77, 0);
    chk("b2b done count", done_cnt - d0, 2);

`ifdef QPP_DEINT_BYPASS_EN
    deint_bypass = 1'b1;
    run_blk("bypass", 1'b0, 8'h99, 1'b0, 1'b0, -1, 8'h99, 1);
    deint_bypass = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
